usb_rx_packet_decoder: RTL and testbench
========================================

# usb_rx_packet_decoder

Receive-side packet layer sitting directly downstream of the USB transceiver byte interface. It consumes the transceiver's byte stream (rx_data/rx_valid/rx_eop/rx_error) and checks each packet's PID, token CRC5, data CRC16 and length. It decodes token fields and streams data payload bytes with the trailing CRC bytes removed. It reports one pass/fail verdict per packet to the device-side protocol engine.

## Interface
- MAX_PAYLOAD, 64: largest accepted data payload in bytes, excluding PID and CRC16.
- clk  in  1  system clock; same domain as the transceiver.
- nRST  in  1  reset, asynchronous, active-low.
- rx_data  in  8  received byte, LSB = first bit on the wire.
- rx_valid  in  1  one-cycle strobe; rx_data holds a new byte.
- rx_eop  in  1  end of packet; a rising edge ends the current packet.
- rx_error  in  1  transceiver error indication; level.
- pid_out  out  4  PID[3:0] of the current packet; holds until the next PID byte.
- pid_valid  out  1  one-cycle pulse when a PID byte passes the check.
- tok_addr  out  7  token address.
- tok_endp  out  4  token endpoint.
- tok_valid  out  1  one-cycle pulse with pkt_done for a good token packet.
- pl_data  out  8  payload byte.
- pl_valid  out  1  one-cycle strobe per payload byte.
- pkt_done  out  1  one-cycle pulse; packet verdict is available.
- pkt_ok  out  1  valid with pkt_done; 1 = packet passed every check.
- err_pid, err_crc, err_len, err_rx  out  1 each  sticky per packet; cleared on the next PID byte; valid with pkt_done.
- busy  out  1  high from the first byte until pkt_done.

## Operation
- States: IDLE, TOKEN, DATA, HSHAKE, DRAIN.
- IDLE: the first rx_valid byte is the PID.
  - PID check: rx_data[7:4] == ~rx_data[3:0], otherwise err_pid.
  - Type is taken from PID[1:0]:
    - 01 = token (OUT 1, IN 9, SOF 5, SETUP D) -> TOKEN.
    - 11 = data (DATA0 3, DATA1 B) -> DATA.
    - 10 = handshake (ACK 2, NAK A, STALL E) -> HSHAKE.
    - 00 (special) -> err_pid.
  - Any err_pid sends the FSM to DRAIN.
- TOKEN: exactly 2 further bytes. Byte1 = {endp[0], addr[6:0]}. Byte2 = {crc5[4:0], endp[3:1]}.
  - CRC5: poly x^5+x^2+1, init 5'b11111, fed the 16 bits LSB-first.
  - Pass when the residual equals 5'b01100; otherwise err_crc.
  - Not exactly 2 bytes -> err_len.
- HSHAKE: zero further bytes; any further byte -> err_len.
- DATA: byte count n after the PID must satisfy 2 <= n <= MAX_PAYLOAD+2, otherwise err_len.
  - CRC16: poly 0x8005, init 0xFFFF, every byte LSB-first including both CRC bytes.
  - Pass when the residual equals 0x800D; otherwise err_crc.
  - A 2-entry hold buffer delays the payload: byte k is emitted on pl_data when byte k+2 arrives. The final 2 bytes (the CRC) are never emitted.
  - When n reaches MAX_PAYLOAD+3: set err_len, stop emission, go to DRAIN.
- DRAIN: bytes are ignored until EOP.
- rx_error high in any non-IDLE state: set err_rx, go to DRAIN.
- On the rx_eop rising edge in any non-IDLE state:
  - Final length and CRC checks run.
  - pkt_done pulses next cycle with pkt_ok = ~(any err).
  - FSM returns to IDLE and busy drops.
- rx_eop rising edge in IDLE with no byte received: ignored, no pkt_done.
- CRC arithmetic: 8 serial steps per byte, unrolled combinationally; registers update only on rx_valid.

## Timing
- Reset: every output is 0, FSM is in IDLE, CRCs are at their init values, the hold buffer is empty. Reset mid-packet aborts the packet with no pkt_done.
- All outputs are registered.
  - pid_valid: 1 cycle after the PID's rx_valid.
  - pl_valid: 1 cycle after the rx_valid of byte k+2.
  - pkt_done: 1 cycle after the rx_eop rising edge.
- rx_valid and the rx_eop rising edge in the same cycle: the byte is processed first and is counted in the checks.
- rx_valid in the cycle pkt_done is high: treated as the PID of a new packet. Error flags clear and the new packet starts.
- tok_addr/tok_endp update at the final token byte and hold until the next token.
- Consumers must discard buffered payload when pkt_ok = 0 at pkt_done.

## Test plan
- SETUP token 2D 00 10 + EOP -> pid_out=D, tok_addr=0, tok_endp=0, tok_valid=1, pkt_ok=1.
- DATA0 C3 80 06 00 01 00 00 40 00 DD 94 + EOP -> 8 pl_valid strobes with 80 06 00 01 00 00 40 00, pkt_ok=1. Same packet with the last byte 95 -> err_crc=1, pkt_ok=0.
- Zero-length DATA1 4B 00 00 -> no pl_valid, pkt_ok=1. DATA0 C3 00 (one byte) -> err_len=1.
- Bad PID 2C followed by 2 bytes -> pid_valid never asserts; err_pid=1 at pkt_done; no tok_valid.
- MAX_PAYLOAD=4, DATA0 with 5 payload bytes plus CRC -> exactly 4 pl_valid strobes, err_len=1, pkt_ok=0. ACK D2 + EOP -> pkt_ok=1.
- rx_error pulsed mid-DATA -> err_rx=1, pl_valid stops, pkt_done at EOP. nRST low mid-packet -> all outputs 0 and no pkt_done. A following ACK decodes cleanly.

Source files
------------

// File: rtl/usb_rx_packet_decoder.sv
// USB receive packet layer: PID, CRC5, CRC16 and length checks, token field decode,
// and payload streaming with the trailing CRC16 bytes held back and never emitted.
module usb_rx_packet_decoder #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       rx_eop_i,
  input  logic       rx_error_i,
  output logic [3:0] pid_out_o,
  output logic       pid_valid_o,
  output logic [6:0] tok_addr_o,
  output logic [3:0] tok_endp_o,
  output logic       tok_valid_o,
  output logic [7:0] pl_data_o,
  output logic       pl_valid_o,
  output logic       pkt_done_o,
  output logic       pkt_ok_o,
  output logic       err_pid_o,
  output logic       err_crc_o,
  output logic       err_len_o,
  output logic       err_rx_o,
  output logic       busy_o
);

  localparam int CW = $clog2(MAX_PAYLOAD + 4);
  localparam logic [CW-1:0] CNT_ABORT = CW'(MAX_PAYLOAD + 3);
  localparam logic [CW-1:0] CNT_TWO   = CW'(2);
  localparam logic [CW-1:0] CNT_THREE = CW'(3);
  localparam logic [4:0]    CRC5_RES  = 5'b01100;
  localparam logic [15:0]   CRC16_RES = 16'h800D;

  typedef enum logic [2:0] {IDLE, TOKEN, DATA, HSHAKE, DRAIN} state_t;

  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] b);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[4] ^ b[i]) r = {r[3:0], 1'b0} ^ 5'b00101;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  state_t        state_q, state_d, fin_state;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0]    crc5_q, crc5_d;
  logic [15:0]   crc16_q, crc16_d;
  logic [7:0]    hold0_q, hold0_d, hold1_q, hold1_d;
  logic [7:0]    byte1_q, byte1_d;
  logic          eop_q, eop_rise;

  logic [3:0] pid_q, pid_d;
  logic       pid_valid_q, pid_valid_d;
  logic [6:0] tok_addr_q, tok_addr_d;
  logic [3:0] tok_endp_q, tok_endp_d;
  logic       tok_valid_q, tok_valid_d;
  logic [7:0] pl_data_q, pl_data_d;
  logic       pl_valid_q, pl_valid_d;
  logic       pkt_done_q, pkt_done_d;
  logic       pkt_ok_q, pkt_ok_d;
  logic       err_pid_q, err_pid_d;
  logic       err_crc_q, err_crc_d;
  logic       err_len_q, err_len_d;
  logic       err_rx_q, err_rx_d;
  logic       busy_q, busy_d;

  assign eop_rise = rx_eop_i & ~eop_q;
  assign cnt_inc  = cnt_q + CW'(1);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      crc5_q      <= 5'h1F;
      crc16_q     <= 16'hFFFF;
      hold0_q     <= '0;
      hold1_q     <= '0;
      byte1_q     <= '0;
      eop_q       <= 1'b0;
      pid_q       <= '0;
      pid_valid_q <= 1'b0;
      tok_addr_q  <= '0;
      tok_endp_q  <= '0;
      tok_valid_q <= 1'b0;
      pl_data_q   <= '0;
      pl_valid_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      err_pid_q   <= 1'b0;
      err_crc_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_rx_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc5_q      <= crc5_d;
      crc16_q     <= crc16_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
      byte1_q     <= byte1_d;
      eop_q       <= rx_eop_i;
      pid_q       <= pid_d;
      pid_valid_q <= pid_valid_d;
      tok_addr_q  <= tok_addr_d;
      tok_endp_q  <= tok_endp_d;
      tok_valid_q <= tok_valid_d;
      pl_data_q   <= pl_data_d;
      pl_valid_q  <= pl_valid_d;
      pkt_done_q  <= pkt_done_d;
      pkt_ok_q    <= pkt_ok_d;
      err_pid_q   <= err_pid_d;
      err_crc_q   <= err_crc_d;
      err_len_q   <= err_len_d;
      err_rx_q    <= err_rx_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fin_state   = state_q;
    cnt_d       = cnt_q;
    crc5_d      = crc5_q;
    crc16_d     = crc16_q;
    hold0_d     = hold0_q;
    hold1_d     = hold1_q;
    byte1_d     = byte1_q;
    pid_d       = pid_q;
    pid_valid_d = 1'b0;
    tok_addr_d  = tok_addr_q;
    tok_endp_d  = tok_endp_q;
    tok_valid_d = 1'b0;
    pl_data_d   = pl_data_q;
    pl_valid_d  = 1'b0;
    pkt_done_d  = 1'b0;
    pkt_ok_d    = 1'b0;
    err_pid_d   = err_pid_q;
    err_crc_d   = err_crc_q;
    err_len_d   = err_len_q;
    err_rx_d    = err_rx_q;

    if (state_q == IDLE) begin
      if (rx_valid_i) begin
        pid_d     = rx_data_i[3:0];
        cnt_d     = '0;
        crc5_d    = 5'h1F;
        crc16_d   = 16'hFFFF;
        err_pid_d = 1'b0;
        err_crc_d = 1'b0;
        err_len_d = 1'b0;
        err_rx_d  = 1'b0;
        // Reserved "special" type (PID[1:0]==00) is rejected like a corrupted PID
        if ((rx_data_i[7:4] != ~rx_data_i[3:0]) || (rx_data_i[1:0] == 2'b00)) begin
          err_pid_d = 1'b1;
          state_d   = DRAIN;
        end else begin
          pid_valid_d = 1'b1;
          case (rx_data_i[1:0])
            2'b01:   state_d = TOKEN;
            2'b11:   state_d = DATA;
            default: state_d = HSHAKE;
          endcase
        end
      end
    end else if (rx_error_i) begin
      err_rx_d = 1'b1;
      state_d  = DRAIN;
    end else if (rx_valid_i) begin
      case (state_q)
        TOKEN: begin
          if (cnt_q == CNT_TWO) begin
            err_len_d = 1'b1;
            state_d   = DRAIN;
          end else begin
            cnt_d  = cnt_inc;
            crc5_d = crc5_byte(crc5_q, rx_data_i);
            if (cnt_q == '0) begin
              byte1_d = rx_data_i;
            end else begin
              tok_addr_d = byte1_q[6:0];
              tok_endp_d = {rx_data_i[2:0], byte1_q[7]};
            end
          end
        end
        DATA: begin
          cnt_d   = cnt_inc;
          crc16_d = crc16_byte(crc16_q, rx_data_i);
          if (cnt_inc == CNT_ABORT) begin
            err_len_d = 1'b1;
            state_d   = DRAIN;
          end else begin
            // Two-deep delay so the final two bytes (CRC16) are never emitted
            if (cnt_inc >= CNT_THREE) begin
              pl_data_d  = hold0_q;
              pl_valid_d = 1'b1;
            end
            hold0_d = hold1_q;
            hold1_d = rx_data_i;
          end
        end
        HSHAKE: begin
          err_len_d = 1'b1;
          state_d   = DRAIN;
        end
        default: ;
      endcase
    end

    if (eop_rise && ((state_q != IDLE) || rx_valid_i)) begin
      fin_state = state_d;
      case (fin_state)
        TOKEN: begin
          if (cnt_d != CNT_TWO)   err_len_d = 1'b1;
          if (crc5_d != CRC5_RES) err_crc_d = 1'b1;
        end
        DATA: begin
          if (cnt_d < CNT_TWO)      err_len_d = 1'b1;
          if (crc16_d != CRC16_RES) err_crc_d = 1'b1;
        end
        default: ;
      endcase
      pkt_done_d  = 1'b1;
      pkt_ok_d    = ~(err_pid_d | err_crc_d | err_len_d | err_rx_d);
      tok_valid_d = (fin_state == TOKEN) && pkt_ok_d;
      state_d     = IDLE;
    end

    busy_d = (state_d != IDLE);
  end

  assign pid_out_o   = pid_q;
  assign pid_valid_o = pid_valid_q;
  assign tok_addr_o  = tok_addr_q;
  assign tok_endp_o  = tok_endp_q;
  assign tok_valid_o = tok_valid_q;
  assign pl_data_o   = pl_data_q;
  assign pl_valid_o  = pl_valid_q;
  assign pkt_done_o  = pkt_done_q;
  assign pkt_ok_o    = pkt_ok_q;
  assign err_pid_o   = err_pid_q;
  assign err_crc_o   = err_crc_q;
  assign err_len_o   = err_len_q;
  assign err_rx_o    = err_rx_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// Directed bench: a default-size decoder and a MAX_PAYLOAD=4 decoder share one stimulus stream.
module tb_usb_rx_packet_decoder;

  logic       clk, nRST;
  logic [7:0] rx_data;
  logic       rx_valid, rx_eop, rx_error;

  logic [3:0] pid_out, pid_out4;
  logic       pid_valid, pid_valid4;
  logic [6:0] tok_addr, tok_addr4;
  logic [3:0] tok_endp, tok_endp4;
  logic       tok_valid, tok_valid4;
  logic [7:0] pl_data, pl_data4;
  logic       pl_valid, pl_valid4;
  logic       pkt_done, pkt_done4, pkt_ok, pkt_ok4;
  logic       err_pid, err_crc, err_len, err_rx, busy;
  logic       err_pid4, err_crc4, err_len4, err_rx4, busy4;

  usb_rx_packet_decoder #(.MAX_PAYLOAD(64)) dut (
    .clk(clk), .nRST(nRST), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_eop_i(rx_eop), .rx_error_i(rx_error), .pid_out_o(pid_out),
    .pid_valid_o(pid_valid), .tok_addr_o(tok_addr), .tok_endp_o(tok_endp),
    .tok_valid_o(tok_valid), .pl_data_o(pl_data), .pl_valid_o(pl_valid),
    .pkt_done_o(pkt_done), .pkt_ok_o(pkt_ok), .err_pid_o(err_pid),
    .err_crc_o(err_crc), .err_len_o(err_len), .err_rx_o(err_rx), .busy_o(busy)
  );

  usb_rx_packet_decoder #(.MAX_PAYLOAD(4)) dut4 (
    .clk(clk), .nRST(nRST), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_eop_i(rx_eop), .rx_error_i(rx_error), .pid_out_o(pid_out4),
    .pid_valid_o(pid_valid4), .tok_addr_o(tok_addr4), .tok_endp_o(tok_endp4),
    .tok_valid_o(tok_valid4), .pl_data_o(pl_data4), .pl_valid_o(pl_valid4),
    .pkt_done_o(pkt_done4), .pkt_ok_o(pkt_ok4), .err_pid_o(err_pid4),
    .err_crc_o(err_crc4), .err_len_o(err_len4), .err_rx_o(err_rx4), .busy_o(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Pulse counters, sampled on the falling edge
  logic [7:0] plq[$];
  int n_pidv = 0, n_tokv = 0, n_done = 0, n_pl4 = 0;
  always @(negedge clk) begin
    if (pl_valid)  plq.push_back(pl_data);
    if (pl_valid4) n_pl4++;
    if (pid_valid) n_pidv++;
    if (tok_valid) n_tokv++;
    if (pkt_done)  n_done++;
  end

  // Values captured at the pkt_done cycle
  logic d_ok, d_pid, d_crc, d_len, d_rx, d_tokv, d4_ok, d4_len;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bs[$]);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  // Raise EOP (optionally together with a final byte) and check the done pulse one cycle later
  task automatic end_pkt(input string tag, input logic with_byte, input logic [7:0] b);
    @(negedge clk);
    rx_eop = 1'b1;
    if (with_byte) begin
      rx_data  = b;
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chk({tag, ".done"}, {63'd0, pkt_done}, 64'd1);
    chk({tag, ".busy"}, {63'd0, busy}, 64'd0);
    d_ok = pkt_ok; d_pid = err_pid; d_crc = err_crc; d_len = err_len; d_rx = err_rx;
    d_tokv = tok_valid; d4_ok = pkt_ok4; d4_len = err_len4;
    rx_eop = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return {31'd0, pid_out, pid_valid, tok_addr, tok_endp, tok_valid, pl_data, pl_valid,
            pkt_done, pkt_ok, err_pid, err_crc, err_len, err_rx, busy};
  endfunction

  initial begin
    int b_pl, b_pidv, b_tokv, b_done, b_pl4;
    logic [63:0] got;

    nRST = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_eop = 1'b0; rx_error = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.outs", all_outs(), 64'd0);
    nRST = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle.outs", all_outs(), 64'd0);

    // SETUP addr 0 endp 0
    b_pidv = n_pidv; b_tokv = n_tokv;
    send_byte(8'h2D);
    chk("setup.pid_valid", {63'd0, pid_valid}, 64'd1);
    chk("setup.busy", {63'd0, busy}, 64'd1);
    send_bytes('{8'h00, 8'h10});
    end_pkt("setup", 1'b0, 8'h00);
    chk("setup.pid", {60'd0, pid_out}, 64'hD);
    chk("setup.addr", {57'd0, tok_addr}, 64'd0);
    chk("setup.endp", {60'd0, tok_endp}, 64'd0);
    chk("setup.tokv", {63'd0, d_tokv}, 64'd1);
    chk("setup.ok", {63'd0, d_ok}, 64'd1);
    chk("setup.npidv", 64'(n_pidv - b_pidv), 64'd1);

    // Same token with the last byte arriving in the EOP cycle
    send_bytes('{8'h2D, 8'h00});
    end_pkt("setup_eop", 1'b1, 8'h10);
    chk("setup_eop.ok", {63'd0, d_ok}, 64'd1);
    chk("setup_eop.tokv", {63'd0, d_tokv}, 64'd1);

    // DATA0 GET_DESCRIPTOR, good CRC
    b_pl = plq.size(); b_tokv = n_tokv;
    send_bytes('{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94});
    end_pkt("data0", 1'b0, 8'h00);
    chk("data0.npl", 64'(plq.size() - b_pl), 64'd8);
    got = '0;
    for (int i = 0; i < 8 && (b_pl + i) < plq.size(); i++) got = {got[55:0], plq[b_pl + i]};
    chk("data0.payload", got, 64'h8006000100004000);
    chk("data0.ok", {63'd0, d_ok}, 64'd1);
    chk("data0.crc", {63'd0, d_crc}, 64'd0);
    chk("data0.ntokv", 64'(n_tokv - b_tokv), 64'd0);

    // Corrupted last CRC byte
    send_bytes('{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h95});
    end_pkt("badcrc", 1'b0, 8'h00);
    chk("badcrc.crc", {63'd0, d_crc}, 64'd1);
    chk("badcrc.ok", {63'd0, d_ok}, 64'd0);

    // Zero-length DATA1
    b_pl = plq.size();
    send_bytes('{8'h4B, 8'h00, 8'h00});
    end_pkt("zlp", 1'b0, 8'h00);
    chk("zlp.npl", 64'(plq.size() - b_pl), 64'd0);
    chk("zlp.ok", {63'd0, d_ok}, 64'd1);
    chk("zlp.pid", {60'd0, pid_out}, 64'hB);

    // DATA0 with a single byte after the PID
    send_bytes('{8'hC3, 8'h00});
    end_pkt("short", 1'b0, 8'h00);
    chk("short.len", {63'd0, d_len}, 64'd1);
    chk("short.ok", {63'd0, d_ok}, 64'd0);

    // Bad PID followed by two bytes
    b_pidv = n_pidv; b_tokv = n_tokv;
    send_bytes('{8'h2C, 8'h00, 8'h10});
    end_pkt("badpid", 1'b0, 8'h00);
    chk("badpid.npidv", 64'(n_pidv - b_pidv), 64'd0);
    chk("badpid.errpid", {63'd0, d_pid}, 64'd1);
    chk("badpid.ntokv", 64'(n_tokv - b_tokv), 64'd0);
    chk("badpid.ok", {63'd0, d_ok}, 64'd0);

    // Oversized packet on the MAX_PAYLOAD=4 decoder: 5 payload bytes + CRC
    b_pl4 = n_pl4;
    send_bytes('{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hAA, 8'hBB});
    end_pkt("ovf4", 1'b0, 8'h00);
    chk("ovf4.npl", 64'(n_pl4 - b_pl4), 64'd4);
    chk("ovf4.len", {63'd0, d4_len}, 64'd1);
    chk("ovf4.ok", {63'd0, d4_ok}, 64'd0);

    // ACK
    send_byte(8'hD2);
    end_pkt("ack", 1'b0, 8'h00);
    chk("ack.ok", {63'd0, d_ok}, 64'd1);
    chk("ack.pid", {60'd0, pid_out}, 64'h2);

    // Handshake with an extra byte
    send_bytes('{8'hD2, 8'h00});
    end_pkt("ackx", 1'b0, 8'h00);
    chk("ackx.len", {63'd0, d_len}, 64'd1);

    // rx_error mid-DATA stops the payload stream
    b_pl = plq.size();
    send_bytes('{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01});
    @(negedge clk); rx_error = 1'b1;
    @(negedge clk); rx_error = 1'b0;
    send_bytes('{8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94});
    end_pkt("rxerr", 1'b0, 8'h00);
    chk("rxerr.npl", 64'(plq.size() - b_pl), 64'd2);
    chk("rxerr.err", {63'd0, d_rx}, 64'd1);
    chk("rxerr.ok", {63'd0, d_ok}, 64'd0);

    // Reset in the middle of a packet
    b_done = n_done;
    send_bytes('{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01});
    @(negedge clk); nRST = 1'b0;
    #1;
    chk("midrst.outs", all_outs(), 64'd0);
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst.ndone", 64'(n_done - b_done), 64'd0);
    send_byte(8'hD2);
    end_pkt("ack2", 1'b0, 8'h00);
    chk("ack2.ok", {63'd0, d_ok}, 64'd1);
    chk("ack2.ndone", 64'(n_done - b_done), 64'd1);

    // EOP in IDLE with nothing received
    b_done = n_done;
    @(negedge clk); rx_eop = 1'b1;
    repeat (2) @(negedge clk); rx_eop = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_eop.ndone", 64'(n_done - b_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
